axi_wb_serializer: RTL and testbench

- Transmit-side counterpart of the cache line fill buffer: takes one dirty cache block and streams it out as an AXI write-data burst, least-significant word first.
- Sits between the cache write-back path and the AXI W channel (optionally the B channel).
- Handles per-beat valid/ready, the beat count and WLAST generation, and signals completion to the cache FSM.

---
 rtl/axi_wb_serializer.sv | 115 +++++++++++
 tb/tb_axi_wb_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wb_serializer.sv
// Streams one cache block out on the AXI W channel, least-significant word first.
// Define AXI_WB_BRESP_EN to also wait for the B response before signalling completion.
module axi_wb_serializer #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH    = 512
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_start,
    input  logic [BLOCK_WIDTH-1:0]    i_data_block,
    output logic                      o_ready,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    output logic [AXI_DATA_WIDTH-1:0] o_wdata,
    output logic                      o_wlast,
    output logic                      o_done
`ifdef AXI_WB_BRESP_EN
    ,
    input  logic                      i_bvalid,
    input  logic [1:0]                i_bresp,
    output logic                      o_bready,
    output logic                      o_error
`endif
);

    localparam int unsigned BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(BEATS - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2
    } state_t;

    state_t               state;
    logic [BLOCK_WIDTH-1:0] sr;
    logic [CNT_W-1:0]     cnt;

    // The current beat is always the low word of the shift register.
    assign o_wdata = sr[AXI_DATA_WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            o_ready  <= 1'b1;
            o_wvalid <= 1'b0;
            o_wlast  <= 1'b0;
            o_done   <= 1'b0;
`ifdef AXI_WB_BRESP_EN
            o_bready <= 1'b0;
            o_error  <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef AXI_WB_BRESP_EN
            o_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sr       <= i_data_block;
                        cnt      <= '0;
                        state    <= SEND;
                        o_ready  <= 1'b0;
                        o_wvalid <= 1'b1;
                        o_wlast  <= 1'b0;
                    end
                end
                SEND: begin
                    // o_wvalid is held high throughout SEND, so i_wready alone marks a handshake.
                    if (i_wready) begin
                        if (cnt == LAST_BEAT) begin
                            o_wvalid <= 1'b0;
                            o_wlast  <= 1'b0;
`ifdef AXI_WB_BRESP_EN
                            state    <= WAIT_B;
                            o_bready <= 1'b1;
`else
                            state    <= IDLE;
                            o_ready  <= 1'b1;
                            o_done   <= 1'b1;
`endif
                        end else begin
                            sr      <= {AXI_DATA_WIDTH'(0), sr[BLOCK_WIDTH-1:AXI_DATA_WIDTH]};
                            cnt     <= cnt + CNT_W'(1);
                            o_wlast <= (cnt == PRE_LAST);
                        end
                    end
                end
`ifdef AXI_WB_BRESP_EN
                WAIT_B: begin
                    if (i_bvalid) begin
                        state    <= IDLE;
                        o_bready <= 1'b0;
                        o_ready  <= 1'b1;
                        o_done   <= 1'b1;
                        o_error  <= (i_bresp != 2'b00);
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    o_ready  <= 1'b1;
                    o_wvalid <= 1'b0;
                    o_wlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wb_serializer.sv
// Directed bench for axi_wb_serializer: 512-bit block, 32-bit beats, 16 beats per burst.
module tb_axi_wb_serializer;

    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = 512;
    localparam int unsigned BEATS = 16;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_start;
    logic [BW-1:0] i_data_block;
    logic          o_ready;
    logic          o_wvalid;
    logic          i_wready;
    logic [DW-1:0] o_wdata;
    logic          o_wlast;
    logic          o_done;
`ifdef AXI_WB_BRESP_EN
    logic          i_bvalid;
    logic [1:0]    i_bresp;
    logic          o_bready;
    logic          o_error;
`endif

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] blk_a, blk_b, blk_c;
    logic [15:0]   pat;
    int            idx;

    always #5 i_clk = ~i_clk;

    axi_wb_serializer #(.AXI_DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_start      (i_start),
        .i_data_block (i_data_block),
        .o_ready      (o_ready),
        .o_wvalid     (o_wvalid),
        .i_wready     (i_wready),
        .o_wdata      (o_wdata),
        .o_wlast      (o_wlast),
        .o_done       (o_done)
`ifdef AXI_WB_BRESP_EN
        ,
        .i_bvalid     (i_bvalid),
        .i_bresp      (i_bresp),
        .o_bready     (o_bready),
        .o_error      (o_error)
`endif
    );

    task automatic chk(input string tag, input int step, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One beat of a burst is on the bus: word base+k, wlast only on the final word.
    task automatic chk_beat(input string tag, input int k, input logic [31:0] base);
        chk({tag, "_wvalid"}, k, 64'(o_wvalid), 64'(1));
        chk({tag, "_wdata"},  k, 64'(o_wdata),  64'(base + 32'(k)));
        chk({tag, "_wlast"},  k, 64'(o_wlast),  64'(k == int'(BEATS) - 1));
        chk({tag, "_done"},   k, 64'(o_done),   64'(0));
        chk({tag, "_ready"},  k, 64'(o_ready),  64'(0));
`ifdef AXI_WB_BRESP_EN
        chk({tag, "_bready"}, k, 64'(o_bready), 64'(0));
`endif
    endtask

    task automatic run_beats(input string tag, input logic [31:0] base);
        for (int k = 0; k < int'(BEATS); k++) begin
            chk_beat(tag, k, base);
            tick();
        end
    endtask

    // Called right after the final W handshake edge; returns in the o_done cycle.
    task automatic expect_done(input string tag, input logic [1:0] bresp);
`ifdef AXI_WB_BRESP_EN
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_wb_bready"}, i, 64'(o_bready), 64'(1));
            chk({tag, "_wb_wvalid"}, i, 64'(o_wvalid), 64'(0));
            chk({tag, "_wb_ready"},  i, 64'(o_ready),  64'(0));
            chk({tag, "_wb_done"},   i, 64'(o_done),   64'(0));
            if (i == 2) begin
                i_bvalid = 1'b1;
                i_bresp  = bresp;
            end
            tick();
        end
        i_bvalid = 1'b0;
        i_bresp  = 2'b00;
        chk({tag, "_error"},  0, 64'(o_error),  64'(bresp != 2'b00));
        chk({tag, "_bready"}, 0, 64'(o_bready), 64'(0));
`endif
        chk({tag, "_done"},   0, 64'(o_done),   64'(1));
        chk({tag, "_ready"},  0, 64'(o_ready),  64'(1));
        chk({tag, "_wvalid"}, 0, 64'(o_wvalid), 64'(0));
    endtask

    initial begin
        for (int k = 0; k < int'(BEATS); k++) begin
            blk_a[k*DW +: DW] = 32'(k + 1);
            blk_b[k*DW +: DW] = 32'(32'h101 + k);
            blk_c[k*DW +: DW] = 32'(32'hA0 + k);
        end
        pat = 16'b0101_1010_0011_1001;

        i_arst       = 1'b1;
        i_start      = 1'b0;
        i_wready     = 1'b0;
        i_data_block = '0;
`ifdef AXI_WB_BRESP_EN
        i_bvalid = 1'b0;
        i_bresp  = 2'b00;
`endif
        #1;
        chk("rst_ready",  0, 64'(o_ready),  64'(1));
        chk("rst_wvalid", 0, 64'(o_wvalid), 64'(0));
        chk("rst_wlast",  0, 64'(o_wlast),  64'(0));
        chk("rst_done",   0, 64'(o_done),   64'(0));
        chk("rst_wdata",  0, 64'(o_wdata),  64'(0));
`ifdef AXI_WB_BRESP_EN
        chk("rst_bready", 0, 64'(o_bready), 64'(0));
        chk("rst_error",  0, 64'(o_error),  64'(0));
`endif
        tick();
        tick();
        i_arst = 1'b0;
        tick();

        // Zero-stall burst: 16 beats then o_done on cycle 17.
        i_data_block = blk_a;
        i_wready     = 1'b1;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        run_beats("t1", 32'h1);
        expect_done("t1", 2'b00);
        tick();
        chk("t1_done_after", 0, 64'(o_done), 64'(0));

        // Stalled burst: outputs must hold while i_wready is low.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        idx = 0;
        for (int c = 0; c < 200 && idx < int'(BEATS); c++) begin
            i_wready = pat[4'(c)];
            chk_beat("t2", idx, 32'h1);
            tick();
            if (i_wready) idx++;
        end
        i_wready = 1'b1;
        expect_done("t2", 2'b00);
        tick();
        chk("t2_done_after", 0, 64'(o_done), 64'(0));

        // A second start mid-burst, plus a changed block, must not disturb the stream.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < int'(BEATS); k++) begin
            i_start = (k == 5);
            if (k == 5) i_data_block = blk_b;
            chk_beat("t3", k, 32'h1);
            tick();
        end
        i_start = 1'b0;
        expect_done("t3", 2'b00);
        tick();

        // Asynchronous reset mid-burst abandons the burst immediately.
        i_data_block = blk_a;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_beat("t4a", k, 32'h1);
            tick();
        end
        i_arst = 1'b1;
        #1;
        chk("t4_rst_wvalid", 0, 64'(o_wvalid), 64'(0));
        chk("t4_rst_ready",  0, 64'(o_ready),  64'(1));
        chk("t4_rst_wlast",  0, 64'(o_wlast),  64'(0));
        tick();
        i_arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_idle_done",   i, 64'(o_done),   64'(0));
            chk("t4_idle_wvalid", i, 64'(o_wvalid), 64'(0));
            tick();
        end
        i_data_block = blk_b;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        run_beats("t4b", 32'h101);
        expect_done("t4b", 2'b00);

        // New start accepted in the o_done cycle: first beat on the very next cycle.
        i_data_block = blk_c;
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        run_beats("t5", 32'hA0);
        expect_done("t5", 2'b10);
        tick();
        chk("t5_done_after", 0, 64'(o_done), 64'(0));
`ifdef AXI_WB_BRESP_EN
        chk("t5_error_after", 0, 64'(o_error), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
